// File: rtl/ulpi_rx_pck_pkg.sv
// ULPI receive-path shared constants: FSM state encoding, FIFO entry tags,
// end-of-packet status codes and the FIFO entry payload layout.
package ulpi_rx_pck_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned TAG_W   = 2;
  localparam int unsigned ENTRY_W = TAG_W + BYTE_W;

  // Receiver FSM states
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_TURN = 2'd1,
    RX_BUS  = 2'd2
  } rx_state_e;

  // FIFO entry tags
  typedef enum logic [TAG_W-1:0] {
    TAG_DATA  = 2'b00,
    TAG_RXCMD = 2'b01,
    TAG_EOP   = 2'b10,
    TAG_RSVD  = 2'b11
  } rx_tag_e;

  // End-of-packet status bytes
  localparam logic [BYTE_W-1:0] EOP_OK   = 8'h00;
  localparam logic [BYTE_W-1:0] EOP_ERR  = 8'h01;
  localparam logic [BYTE_W-1:0] EOP_DROP = 8'h02;
  localparam logic [BYTE_W-1:0] EOP_BOTH = 8'h03;

  // RX CMD RxEvent field value for RxError
  localparam logic [1:0] RXEV_ERROR = 2'b11;

  // One FIFO entry
  typedef struct packed {
    rx_tag_e           tag;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

  // Packet status byte from the error and drop flags
  function automatic logic [BYTE_W-1:0] eop_status(input logic err, input logic drop);
    logic [BYTE_W-1:0] s;
    unique case ({drop, err})
      2'b00:   s = EOP_OK;
      2'b01:   s = EOP_ERR;
      2'b10:   s = EOP_DROP;
      default: s = EOP_BOTH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ulpi_rx_fifo.sv
// ULPI_RX_FIFO: first-word fall-through FIFO for tagged receive entries.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i/data_i  write request and entry
//   pop_i          read request (ignored when empty)
//   head_o         current head entry, straight from the storage registers
//   valid_o        FIFO non-empty
//   drop_o         this cycle's push is discarded (full and no pop)
module ulpi_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_c, pop_c, accept_c;

  // A pop frees the slot a same-cycle push into a full FIFO needs
  assign full_c   = (count_q == CW'(DEPTH));
  assign pop_c    = pop_i && (count_q != '0);
  assign accept_c = push_i && (!full_c || pop_c);

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign drop_o  = push_i && full_c && !pop_c;

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)    rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({accept_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage, no reset needed: contents are qualified by count_q
  always_ff @(posedge clk_i) begin
    if (accept_c) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ulpi_rx_pck.sv
// ULPI_RX_PCK: classifies ULPI receive bytes (data / RX CMD / end-of-packet
// status) and queues them as tagged entries in ULPI_RX_FIFO.
// Ports:
//   clk_ext, rst          60 MHz PHY clock, synchronous active-high reset
//   EN                    receiver enable (bytes still tracked when 0)
//   DIR, NXT, ULPI_DATA_IN  ULPI bus input view
//   RD_EN                 consumer pop
//   OUT_DATA/OUT_TAG/OUT_VALID  FIFO head (first-word fall-through)
//   LINESTATE             line state of the last RX CMD
//   RX_ACTIVE             packet in progress
//   BUSY                  FSM away from RX_IDLE
//   OVERFLOW              sticky: an entry was dropped on a full FIFO
module ulpi_rx_pck
  import ulpi_rx_pck_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter bit          RXCMD_FILTER = 1'b1
) (
  input  logic              clk_ext,
  input  logic              rst,
  input  logic              EN,
  input  logic              DIR,
  input  logic              NXT,
  input  logic [BYTE_W-1:0] ULPI_DATA_IN,
  input  logic              RD_EN,
  output logic [BYTE_W-1:0] OUT_DATA,
  output logic [TAG_W-1:0]  OUT_TAG,
  output logic              OUT_VALID,
  output logic [1:0]        LINESTATE,
  output logic              RX_ACTIVE,
  output logic              BUSY,
  output logic              OVERFLOW
);

  rx_state_e         state_q, state_d;
  logic              rx_active_q, rx_active_d;
  logic [1:0]        linestate_q, linestate_d;
  logic [BYTE_W-1:0] last_cmd_q, last_cmd_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic              eop_pend_q, eop_pend_d;
  logic              ovf_q, ovf_d;
  logic              stg_vld_q, stg_vld_d;
  rx_entry_t         stg_q, stg_d;

  logic              start_c, err_set_c, eop_req_c, new_act_c;
  logic              fifo_drop_c;
  logic [ENTRY_W-1:0] fifo_head_c;
  rx_entry_t         head_c;

  // Classification and FSM next state
  always_comb begin
    state_d     = state_q;
    rx_active_d = rx_active_q;
    linestate_d = linestate_q;
    last_cmd_d  = last_cmd_q;
    eop_pend_d  = 1'b0;
    stg_vld_d   = 1'b0;
    stg_d       = '0;
    start_c     = 1'b0;
    err_set_c   = 1'b0;
    eop_req_c   = 1'b0;
    new_act_c   = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (DIR) state_d = RX_TURN;
      end
      RX_TURN: begin
        if (DIR) begin
          state_d = RX_BUS;
          // NXT during turnaround: RxActive without an RX CMD
          if (NXT && !rx_active_q) begin
            rx_active_d = 1'b1;
            start_c     = 1'b1;
          end
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_BUS: begin
        if (!DIR) begin
          state_d = RX_IDLE;
          if (rx_active_q) begin
            rx_active_d = 1'b0;
            eop_req_c   = 1'b1;
          end
        end else if (NXT) begin
          if (EN && rx_active_q) begin
            stg_vld_d = 1'b1;
            stg_d     = '{tag: TAG_DATA, data: ULPI_DATA_IN};
          end
        end else begin
          linestate_d = ULPI_DATA_IN[1:0];
          new_act_c   = (ULPI_DATA_IN[5:4] != 2'b00);
          rx_active_d = new_act_c;
          start_c     = !rx_active_q && new_act_c;
          err_set_c   = (ULPI_DATA_IN[5:4] == RXEV_ERROR);
          // EOP follows its RX CMD one cycle later to keep entry order
          eop_pend_d  = rx_active_q && !new_act_c;
          // A pending EOP owns this cycle's push slot
          if (EN && !eop_pend_q &&
              (!RXCMD_FILTER || (ULPI_DATA_IN != last_cmd_q))) begin
            stg_vld_d  = 1'b1;
            stg_d      = '{tag: TAG_RXCMD, data: ULPI_DATA_IN};
            last_cmd_d = ULPI_DATA_IN;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Status includes a drop of the entry being written this very cycle
    if (eop_pend_q || eop_req_c) begin
      stg_vld_d = 1'b1;
      stg_d     = '{tag: TAG_EOP, data: eop_status(err_q, drop_q | fifo_drop_c)};
    end
  end

  // Packet flags restart with each packet; stale drops of the previous one are ignored
  always_comb begin
    if (start_c) begin
      err_d  = err_set_c;
      drop_d = 1'b0;
    end else begin
      err_d  = err_q | err_set_c;
      drop_d = drop_q | fifo_drop_c;
    end
    ovf_d = ovf_q | fifo_drop_c;
  end

  // State and pipeline registers
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      rx_active_q <= 1'b0;
      linestate_q <= 2'b00;
      last_cmd_q  <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      eop_pend_q  <= 1'b0;
      ovf_q       <= 1'b0;
      stg_vld_q   <= 1'b0;
      stg_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_active_q <= rx_active_d;
      linestate_q <= linestate_d;
      last_cmd_q  <= last_cmd_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      eop_pend_q  <= eop_pend_d;
      ovf_q       <= ovf_d;
      stg_vld_q   <= stg_vld_d;
      stg_q       <= stg_d;
    end
  end

  // Output queue, fed from the one-entry push stage
  ulpi_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_ext),
    .rst_i   (rst),
    .push_i  (stg_vld_q),
    .data_i  (stg_q),
    .pop_i   (RD_EN),
    .head_o  (fifo_head_c),
    .valid_o (OUT_VALID),
    .drop_o  (fifo_drop_c)
  );

  assign head_c    = rx_entry_t'(fifo_head_c);
  assign OUT_DATA  = head_c.data;
  assign OUT_TAG   = head_c.tag;
  assign LINESTATE = linestate_q;
  assign RX_ACTIVE = rx_active_q;
  assign BUSY      = (state_q != RX_IDLE);
  assign OVERFLOW  = ovf_q;

endmodule

// File: doc/ulpi_rx_pck.md
ULPI_RX_PCK -- requirements
Module: ULPI_RX_PCK

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output FIFO entries (power of two, 4..64).
REQ-002 Parameter RXCMD_FILTER, default 1; 1 = push an RX CMD only when its value differs from the last pushed RX CMD.
REQ-003 clk_ext  in  1  60 MHz PHY clock, sole clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 EN  in  1  receiver enable; 0 = bytes are observed but not pushed.
REQ-006 DIR  in  1  ULPI DIR.
REQ-007 NXT  in  1  ULPI NXT.
REQ-008 ULPI_DATA_IN  in  8  ULPI data bus, input view.
REQ-009 RD_EN  in  1  consumer pop request.
REQ-010 OUT_DATA  out  8  FIFO head byte.
REQ-011 OUT_TAG  out  2  head tag: 00 data, 01 RX CMD, 10 end-of-packet status, 11 reserved.
REQ-012 OUT_VALID  out  1  FIFO non-empty.
REQ-013 LINESTATE  out  2  RX CMD[1:0] of the last RX CMD received.
REQ-014 RX_ACTIVE  out  1  packet currently in progress.
REQ-015 BUSY  out  1  state != RX_IDLE.
REQ-016 OVERFLOW  out  1  sticky; a push was dropped because the FIFO was full.

Function
REQ-017 States: RX_IDLE, RX_TURN, RX_BUS; registered, advance only on clk_ext.
REQ-018 RX_IDLE: DIR=1 -> RX_TURN; ULPI_DATA_IN ignored in this cycle.
REQ-019 RX_TURN: one-cycle turnaround; data ignored; DIR=1 -> RX_BUS, DIR=0 -> RX_IDLE.
REQ-020 In RX_TURN, NXT=1 sets RX_ACTIVE and pushes nothing (implied RxActive start).
REQ-021 RX_BUS with DIR=1, NXT=1: byte is packet data; push {00, byte} when EN=1 and RX_ACTIVE=1.
REQ-022 RX_BUS with DIR=1, NXT=0: byte is an RX CMD; update LINESTATE; RX_ACTIVE <= (byte[5:4] != 00); push {01, byte} subject to RXCMD_FILTER and EN.
REQ-023 RX CMD with byte[5:4]=11 (RxError) marks the current packet errored.
REQ-024 RX_ACTIVE falling (RX CMD or DIR=0) pushes {10, status}: 0x00 ok, 0x01 RxError, 0x02 bytes dropped during the packet, 0x03 both.
REQ-025 RX_BUS with DIR=0 -> RX_IDLE (turnaround cycle, data ignored); RX_ACTIVE cleared, EOP pushed if it was 1.
REQ-026 One push per cycle at most; a data push and an EOP push never coincide (EOP is triggered only by an NXT=0 cycle or DIR=0).
REQ-027 FIFO: first-word fall-through; OUT_* reflect the head combinationally from registers; pop when RD_EN=1 and OUT_VALID=1; RD_EN on empty is ignored.
REQ-028 Simultaneous push and pop when full: both take effect, nothing dropped.
REQ-029 Push when full (no pop): entry dropped, OVERFLOW <= 1, packet drop flag set.
REQ-030 EOP push when full: dropped as in REQ-029; the following packet is not affected.
REQ-031 OVERFLOW clears only on rst.
REQ-032 Latency: a byte sampled at edge N is visible on OUT_* after edge N+1 when the FIFO is empty.
REQ-033 Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-034 rst=1 at any edge: state RX_IDLE, FIFO emptied, RX_ACTIVE=0, LINESTATE=00, OVERFLOW=0, last-RX-CMD register=0x00, error/drop flags=0.
REQ-035 rst mid-packet: no EOP entry emitted; on release with DIR=1, RX_TURN is entered first.

Structure
REQ-036 Tag codes, EOP status codes and state encodings are kept in a shared ULPI constants include, reused by the top-level ULPI controller.
REQ-037 The FIFO is a sub-module named ULPI_RX_FIFO (parameterized width 10, depth FIFO_DEPTH); the FSM and classification logic live in ULPI_RX_PCK.

Verification
REQ-038 Scenario 1: DIR rises; RX CMD 0x15 (RxActive); data A5,3C,0F with NXT=1; RX CMD 0x01; DIR falls -> FIFO holds {01,15},{00,A5},{00,3C},{00,0F},{01,01},{10,00}.
REQ-039 Scenario 2: DIR and NXT rise together; data 11,22; DIR falls -> {00,11},{00,22},{10,00}; RX_ACTIVE high from the turnaround edge to DIR fall.
REQ-040 Scenario 3: packet containing RX CMD 0x31 (RxError) -> EOP entry {10,01}.
REQ-041 Scenario 4: RD_EN=0, 20 data bytes, FIFO_DEPTH=16 -> 16 entries kept, OVERFLOW=1; after draining, next clean packet ends {10,00}.
REQ-042 Scenario 5: rst asserted mid-packet -> OUT_VALID=0, BUSY=0 next cycle; no EOP entry.
REQ-043 Scenario 6: two identical RX CMDs 0x01 with RXCMD_FILTER=1 -> one entry; with RXCMD_FILTER=0 -> two entries.
